title_rect_ctrl: RTL and testbench
==================================

TITLE_RECT_CTRL -- requirements
Module: title_rect_ctrl

Interface
REQ-001 The block SHALL have parameters: OBJECT_WIDTH_X 57, sprite width in pixels; OBJECT_HEIGHT_Y 30, sprite height in pixels; TOP_X 291, fixed left column; FINAL_Y 100, resting top row; SPEED_Y 4, rows moved per frame; HOLD_FRAMES 60; BLINK_FRAMES 64; BLINK_PERIOD 8.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 resetN  in  1  asynchronous, active-high reset (asserted when 1).
REQ-004 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-005 pixelX  in  11  current pixel column, unsigned.
REQ-006 pixelY  in  11  current pixel row, unsigned.
REQ-007 start  in  1  one-cycle pulse that begins the title sequence.
REQ-008 skip  in  1  one-cycle pulse that jumps straight to the final position.
REQ-009 offsetX  out  11  pixel column relative to the sprite top-left.
REQ-010 offsetY  out  11  pixel row relative to the sprite top-left.
REQ-011 InsideRectangle  out  1  current pixel is inside the visible sprite rectangle.
REQ-012 titleDone  out  1  level, high in DONE.

Function
REQ-013 State machine states: IDLE, SLIDE, HOLD, BLINK, DONE.
REQ-014 topLeftY SHALL be a signed 12-bit register; topLeftX SHALL be the constant TOP_X.
REQ-015 IDLE: sprite invisible; on start, go to SLIDE and load topLeftY = -OBJECT_HEIGHT_Y.
REQ-016 SLIDE: on each startOfFrame, topLeftY += SPEED_Y, clamped to FINAL_Y. Reaching FINAL_Y moves the FSM to HOLD and clears the frame counter.
REQ-017 HOLD: count startOfFrame pulses; after HOLD_FRAMES pulses, go to BLINK and clear the counter.
REQ-018 BLINK: visible = NOT counter[log2(BLINK_PERIOD)], so visibility toggles every BLINK_PERIOD frames, starting visible; after BLINK_FRAMES pulses, go to DONE.
REQ-019 DONE: sprite visible at FINAL_Y and titleDone = 1; start returns to SLIDE with topLeftY = -OBJECT_HEIGHT_Y.
REQ-020 skip in any state SHALL force DONE with topLeftY = FINAL_Y. skip has priority over start and startOfFrame.
REQ-021 start SHALL be ignored in SLIDE, HOLD and BLINK.
REQ-022 start coincident with startOfFrame in IDLE: load -OBJECT_HEIGHT_Y only; the first move happens on the next startOfFrame.
REQ-023 Position and counters SHALL change only on startOfFrame cycles, apart from the start and skip loads.
REQ-024 Hit test: inside = visible AND pixelX >= TOP_X AND pixelX < TOP_X+OBJECT_WIDTH_X AND signed(pixelY) >= topLeftY AND signed(pixelY) < topLeftY+OBJECT_HEIGHT_Y. The compare SHALL be 12-bit signed so partially off-screen rows clip correctly.
REQ-025 Outputs SHALL be registered with 1-cycle latency from pixelX/pixelY.
REQ-026 When inside, offsetX = pixelX-TOP_X and offsetY = pixelY-topLeftY (low 11 bits); when not inside, both SHALL be 0.
REQ-027 offsetY SHALL always be in 0..OBJECT_HEIGHT_Y-1 and offsetX in 0..OBJECT_WIDTH_X-1 while InsideRectangle = 1.
REQ-028 The hit test SHALL use the topLeftY value registered before the current edge; an update on a startOfFrame cycle affects the hit test from the next cycle.

Reset
REQ-029 Asserting resetN SHALL immediately force state IDLE, topLeftY = -OBJECT_HEIGHT_Y, counter 0, offsetX = 0, offsetY = 0, InsideRectangle = 0, titleDone = 0.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence; after release the block waits in IDLE for start.

Verification
REQ-031 After reset, with no start: pixel (300,50) -> InsideRectangle = 0, offsets (0,0) indefinitely.
REQ-032 start, then 5 startOfFrame pulses -> topLeftY = -10. Pixel (300,0) -> one cycle later InsideRectangle = 1, offset (9,10). Pixel (300,19) -> offset (9,29); pixel (300,20) -> InsideRectangle = 0.
REQ-033 start, then 33 startOfFrame pulses -> topLeftY = 100 (clamped from 102), state HOLD. Pixel (291,100) -> offset (0,0); (347,129) -> (56,29); (348,129) and (290,100) -> InsideRectangle = 0.
REQ-034 After HOLD, during BLINK: frames 0-7 visible, 8-15 invisible at pixel (300,110); after 64 pulses titleDone = 1 and the sprite is visible.
REQ-035 skip at slide frame 10 -> next cycle state DONE, titleDone = 1, pixel (291,100) -> offset (0,0). start in the same cycle as skip is ignored.
REQ-036 resetN pulsed during BLINK -> titleDone = 0 and InsideRectangle = 0 asynchronously; a new start restarts the slide from -30.

Source files
------------

// File: rtl/title_rect_ctrl.sv
// Title sprite controller: slides a fixed-column sprite down from above the
// screen, holds it, blinks it, then parks it at its resting row.
module title_rect_ctrl #(
    parameter int OBJECT_WIDTH_X  = 57,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int TOP_X           = 291,
    parameter int FINAL_Y         = 100,
    parameter int SPEED_Y         = 4,
    parameter int HOLD_FRAMES     = 60,
    parameter int BLINK_FRAMES    = 64,
    parameter int BLINK_PERIOD    = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        start,
    input  logic        skip,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        titleDone
);

    typedef enum logic [2:0] {
        IDLE,
        SLIDE,
        HOLD,
        BLINK,
        DONE
    } state_t;

    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BB      = $clog2(BLINK_PERIOD);

    localparam logic signed [11:0] START_Y  = 12'(-OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] FINAL_S  = 12'(FINAL_Y);
    localparam logic signed [11:0] SPEED_S  = 12'(SPEED_Y);
    localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HEIGHT_Y);
    localparam logic [10:0]        X_LO     = 11'(TOP_X);
    localparam logic [10:0]        X_HI     = 11'(TOP_X + OBJECT_WIDTH_X);
    localparam logic [CW-1:0]      HOLD_LAST  = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0]      BLINK_LAST = CW'(BLINK_FRAMES - 1);

    state_t                state_q, state_d;
    logic signed [11:0]    top_y_q, top_y_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [10:0]           off_x_q, off_x_d;
    logic [10:0]           off_y_q, off_y_d;
    logic                  inside_q, inside_d;

    logic signed [11:0]    step_y;
    logic signed [11:0]    py_s;
    logic signed [11:0]    rel_y;
    logic                  visible;
    logic                  in_x;
    logic                  in_y;

    assign step_y = top_y_q + SPEED_S;

    always_comb begin
        state_d = state_q;
        top_y_d = top_y_q;
        cnt_d   = cnt_q;
        if (skip) begin
            state_d = DONE;
            top_y_d = FINAL_S;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // A frame pulse alongside start only loads; motion begins next frame.
                    if (start) begin
                        state_d = SLIDE;
                        top_y_d = START_Y;
                        cnt_d   = '0;
                    end
                end
                SLIDE: begin
                    if (startOfFrame) begin
                        if (step_y >= FINAL_S) begin
                            state_d = HOLD;
                            top_y_d = FINAL_S;
                            cnt_d   = '0;
                        end else begin
                            top_y_d = step_y;
                        end
                    end
                end
                HOLD: begin
                    if (startOfFrame) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = BLINK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                BLINK: begin
                    if (startOfFrame) begin
                        if (cnt_q == BLINK_LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        visible = 1'b1;
        if (state_q == IDLE) begin
            visible = 1'b0;
        end else if (state_q == BLINK) begin
            visible = ~cnt_q[BB];
        end
    end

    // Signed row compare lets rows above the screen clip cleanly.
    assign py_s  = {1'b0, pixelY};
    assign rel_y = py_s - top_y_q;
    assign in_x  = (pixelX >= X_LO) && (pixelX < X_HI);
    assign in_y  = (py_s >= top_y_q) && (py_s < (top_y_q + HEIGHT_S));

    always_comb begin
        inside_d = visible && in_x && in_y;
        off_x_d  = '0;
        off_y_d  = '0;
        if (inside_d) begin
            off_x_d = pixelX - X_LO;
            off_y_d = rel_y[10:0];
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q  <= IDLE;
            top_y_q  <= START_Y;
            cnt_q    <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            inside_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            top_y_q  <= top_y_d;
            cnt_q    <= cnt_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            inside_q <= inside_d;
        end
    end

    assign offsetX         = off_x_q;
    assign offsetY         = off_y_q;
    assign InsideRectangle = inside_q;
    assign titleDone       = (state_q == DONE);

endmodule

// File: tb/tb_title_rect_ctrl.sv
// Scoreboard bench for title_rect_ctrl: expected hit results are queued
// as each pixel is driven and retired one cycle later.
module tb_title_rect_ctrl;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        start;
    logic        skip;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        titleDone;

    int n_chk;
    int n_fail;
    logic [22:0] exp_q[$];

    title_rect_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .start          (start),
        .skip           (skip),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .InsideRectangle(InsideRectangle),
        .titleDone      (titleDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic s_sof, input logic s_st, input logic s_sk,
                        input int x, input int y);
        @(negedge clk);
        startOfFrame = s_sof;
        start        = s_st;
        skip         = s_sk;
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        start        = 1'b0;
        skip         = 1'b0;
    endtask

    task automatic sofs(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic probe(input logic sof, input int x, input int y,
                         input logic ein, input int ox, input int oy);
        logic [22:0] e;
        exp_q.push_back({ein, 11'(ox), 11'(oy)});
        step(sof, 1'b0, 1'b0, x, y);
        e = exp_q.pop_front();
        check($sformatf("inside(%0d,%0d)", x, y), 32'(InsideRectangle), 32'(e[22]));
        check($sformatf("offX(%0d,%0d)", x, y), 32'(offsetX), 32'(e[21:11]));
        check($sformatf("offY(%0d,%0d)", x, y), 32'(offsetY), 32'(e[10:0]));
    endtask

    initial begin
        logic v;
        n_chk        = 0;
        n_fail       = 0;
        resetN       = 1'b1;
        startOfFrame = 1'b0;
        start        = 1'b0;
        skip         = 1'b0;
        pixelX       = '0;
        pixelY       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_inside", 32'(InsideRectangle), 0);
        check("rst_done", 32'(titleDone), 0);
        check("rst_offX", 32'(offsetX), 0);
        check("rst_offY", 32'(offsetY), 0);
        @(negedge clk);
        resetN = 1'b0;

        // idle: nothing visible, even across frames
        probe(0, 300, 50, 0, 0, 0);
        probe(1, 300, 50, 0, 0, 0);
        sofs(3);
        probe(0, 300, 50, 0, 0, 0);
        check("idle_done", 32'(titleDone), 0);

        // slide: five frames puts the top row at -10
        step(0, 1, 0, 0, 0);
        sofs(5);
        probe(0, 300, 0, 1, 9, 10);
        probe(0, 300, 19, 1, 9, 29);
        probe(0, 300, 20, 0, 0, 0);
        sofs(27);
        probe(0, 291, 98, 1, 0, 0);
        sofs(1);
        probe(0, 291, 100, 1, 0, 0);
        probe(0, 347, 129, 1, 56, 29);
        probe(0, 348, 129, 0, 0, 0);
        probe(0, 290, 100, 0, 0, 0);
        probe(0, 291, 99, 0, 0, 0);
        check("hold_done", 32'(titleDone), 0);

        // hold then blink; probes share the frame-pulse cycle
        for (int f = 0; f < 60; f++) probe(1, 300, 110, 1, 9, 10);
        check("blink_done0", 32'(titleDone), 0);
        for (int f = 0; f < 64; f++) begin
            v = ((f & 8) == 0);
            probe(1, 300, 110, v, v ? 9 : 0, v ? 10 : 0);
        end
        check("done_level", 32'(titleDone), 1);
        probe(0, 291, 100, 1, 0, 0);

        // restart from done, then skip mid-slide with a coincident start
        step(0, 1, 0, 0, 0);
        check("restart_done", 32'(titleDone), 0);
        probe(0, 300, 0, 0, 0, 0);
        sofs(1);
        probe(0, 291, 3, 1, 0, 29);
        probe(0, 291, 4, 0, 0, 0);
        sofs(9);
        step(0, 1, 1, 0, 0);
        check("skip_done", 32'(titleDone), 1);
        probe(0, 291, 100, 1, 0, 0);
        sofs(2);
        probe(0, 291, 100, 1, 0, 0);
        check("skip_stay", 32'(titleDone), 1);

        // start is ignored while sliding
        step(0, 1, 0, 0, 0);
        sofs(3);
        step(0, 1, 0, 0, 0);
        sofs(1);
        probe(0, 291, 0, 1, 0, 14);
        sofs(29);
        probe(0, 291, 100, 1, 0, 0);
        sofs(60);
        sofs(3);
        probe(0, 300, 110, 1, 9, 10);

        // asynchronous reset in blink
        @(negedge clk);
        #2;
        resetN = 1'b1;
        #1;
        check("arst_inside", 32'(InsideRectangle), 0);
        check("arst_done", 32'(titleDone), 0);
        check("arst_offX", 32'(offsetX), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b0;
        probe(0, 300, 110, 0, 0, 0);

        // start with a frame pulse only loads the start row
        step(1, 1, 0, 0, 0);
        probe(0, 300, 0, 0, 0, 0);
        sofs(1);
        probe(0, 291, 3, 1, 0, 29);
        probe(0, 291, 4, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
